muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the CPU's iterative multiply and divide units. It accepts single-cycle start requests from the main control unit, pulses the selected unit's init input, and counts its iteration cycles. It then commits the result to the HI/LO registers or raises a divide-by-zero exception. While an operation is in flight it holds `busy` high, and the main control unit stalls on that.

## Interface
- `DIV_CYCLES`, default 32: iteration cycles the divider needs after its init cycle.
- `MULT_CYCLES`, default 32: iteration cycles the multiplier needs after its init cycle.
- `CNT_W`, default 6: counter width; must satisfy 2^CNT_W > max(DIV_CYCLES, MULT_CYCLES).

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start_mult` in 1: request a multiply; sampled only in IDLE.
- `start_div` in 1: request a divide; sampled only in IDLE.
- `div_ok` in 1: divider status; low means the divider rejected a zero denominator.
- `mult_init` out 1: init pulse to the multiplier.
- `div_init` out 1: init pulse to the divider.
- `busy` out 1: operation in flight; the main control unit holds the pipeline.
- `hilo_we` out 1: write enable for the HI/LO registers.
- `hilo_sel` out 1: HI/LO source select; 0 = multiplier, 1 = divider.
- `done` out 1: one-cycle completion pulse, either normal or exception.
- `div_zero_exc` out 1: one-cycle divide-by-zero exception pulse to the control unit.

## Operation
- States: IDLE, INIT, RUN, COMMIT, ZERO. `op` is a registered flag: 0 = mult, 1 = div.
- IDLE
  - `start_div` → INIT with op=1.
  - Otherwise `start_mult` → INIT with op=0.
  - If both are high in the same cycle, the divide wins and the multiply is dropped. No queueing.
- INIT (1 cycle)
  - `div_init` = op, `mult_init` = !op.
  - Counter loads 0. Next state RUN.
- RUN
  - Counter increments every cycle.
  - On the first RUN cycle (count 0) with op=1 and `div_ok`=0 → ZERO. `div_ok` is ignored in all other cycles and for multiplies.
  - Leaves to COMMIT on the cycle where count = N−1, where N = DIV_CYCLES for op=1 and MULT_CYCLES for op=0.
- COMMIT (1 cycle)
  - `hilo_we`=1, `done`=1. Next state IDLE.
- ZERO (1 cycle)
  - `div_zero_exc`=1, `done`=1, `hilo_we`=0. HI/LO is left unchanged. Next state IDLE.
- `hilo_sel` = op, driven registered and held stable from INIT through COMMIT/ZERO. It keeps its last value in IDLE.
- `busy` = 1 in INIT, RUN, COMMIT and ZERO; 0 in IDLE. It is registered and decoded from state.
- All outputs are decoded from registered state and `op`. No input-to-output combinational paths.
- Start requests arriving outside IDLE are ignored, including in COMMIT and ZERO.
- Counter does not wrap: it is only used in RUN and is reloaded in INIT.

## Timing
- Reset: state=IDLE, op=0, count=0. All outputs are 0, including `hilo_sel`.
- Reset during any state returns to IDLE on that edge with no `hilo_we`, `done` or exception pulse. The datapath units share the same reset.
- Start sampled at edge E.
  - INIT occupies cycle E+1.
  - RUN occupies E+2 .. E+N+1.
  - COMMIT occupies E+N+2.
  - IDLE resumes at E+N+3.
- Default divide: `busy` high for 34 cycles, `hilo_we` in the 34th cycle after the start edge.
- Divide-by-zero: the divider flags the zero denominator at the end of INIT, so `div_ok` is checked in E+2. ZERO occupies E+3 and IDLE resumes at E+4. `busy` is high for 3 cycles.
- A new start can be accepted in the first IDLE cycle after COMMIT or ZERO. Back-to-back operations therefore have a one-cycle gap.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, `busy`=0.
- `start_div` pulse with `div_ok`=1:
  - `div_init`=1 for exactly one cycle.
  - `busy` high 34 cycles.
  - `hilo_we`=`done`=1 on cycle E+34 with `hilo_sel`=1.
  - `busy`=0 on E+35.
- `start_div` with `div_ok` driven 0 from E+2 → `div_zero_exc`=`done`=1 on E+3, `hilo_we` never asserted, `busy`=0 on E+4.
- `start_mult` and `start_div` in the same cycle → only `div_init` pulses, `hilo_sel`=1. A second `start_mult` issued mid-RUN produces no `mult_init`.
- `reset` asserted at RUN count 10 of a divide → IDLE next cycle, no `hilo_we`/`done`. A fresh `start_mult` then completes normally with `hilo_sel`=0 after MULT_CYCLES+2 cycles.
- Back-to-back: `start_mult` in the first IDLE cycle after a COMMIT → accepted, `mult_init` on the next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Bundles the start/status/result-control signals that pass between the
//   main control unit, the iterative multiply/divide units and the
//   muldiv_ctrl sequencer.
//
//   Handshake: start_mult/start_div are single-cycle request pulses. The
//   sequencer samples them only while idle. Requests that arrive while busy
//   is high are dropped and never queued. The requester treats busy as its
//   stall signal. done marks completion for exactly one cycle.
//
//   slave  : the sequencer side. It receives the requests and div_ok, and
//            drives the init pulses, busy and the HI/LO controls.
//   master : the environment side. It drives the requests and div_ok.
interface muldiv_ctrl_if;
    logic start_mult;    // request a multiply
    logic start_div;     // request a divide
    logic div_ok;        // divider status, low = zero denominator
    logic mult_init;     // init pulse to the multiplier
    logic div_init;      // init pulse to the divider
    logic busy;          // operation in flight
    logic hilo_we;       // HI/LO write enable
    logic hilo_sel;      // HI/LO source: 0 = multiplier, 1 = divider
    logic done;          // one-cycle completion pulse
    logic div_zero_exc;  // one-cycle divide-by-zero exception pulse

    modport slave (
        input  start_mult, start_div, div_ok,
        output mult_init, div_init, busy, hilo_we, hilo_sel, done, div_zero_exc
    );

    modport master (
        output start_mult, start_div, div_ok,
        input  mult_init, div_init, busy, hilo_we, hilo_sel, done, div_zero_exc
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequencer for the iterative multiply and divide units. It accepts a
//   start request while idle and pulses the selected unit's init input for
//   one cycle. It then counts the unit's iteration cycles and finishes in
//   one of two ways: it commits the result to HI/LO, or it raises a
//   divide-by-zero exception when the divider rejects its denominator.
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : muldiv_ctrl_if.slave (requests, div_ok, init pulses, busy,
//               HI/LO controls, done, div_zero_exc)
//   dbg_state : current FSM state (0 IDLE, 1 INIT, 2 RUN, 3 COMMIT, 4 ZERO)
//
// Every output is a flop. Its next value is decoded from the next state and
// the next op, so the outputs line up with the state register and no input
// reaches an output combinationally.
module muldiv_ctrl #(
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_ctrl_if.slave     bus,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_COMMIT = 3'd3,
        S_ZERO   = 3'd4
    } state_e;

    // Last RUN count for each unit. RUN lasts N cycles, with counts 0..N-1.
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             op_q, op_d;        // 0 = multiply, 1 = divide
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mult_init_q, mult_init_d;
    logic div_init_q, div_init_d;
    logic busy_q, busy_d;
    logic hilo_we_q, hilo_we_d;
    logic hilo_sel_q, hilo_sel_d;
    logic done_q, done_d;
    logic div_zero_exc_q, div_zero_exc_d;

    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = op_q ? DIV_LAST : MULT_LAST;

    // State register, plus the registered copies of the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= 1'b0;
            cnt_q          <= '0;
            mult_init_q    <= 1'b0;
            div_init_q     <= 1'b0;
            busy_q         <= 1'b0;
            hilo_we_q      <= 1'b0;
            hilo_sel_q     <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            mult_init_q    <= mult_init_d;
            div_init_q     <= div_init_d;
            busy_q         <= busy_d;
            hilo_we_q      <= hilo_we_d;
            hilo_sel_q     <= hilo_sel_d;
            done_q         <= done_d;
            div_zero_exc_q <= div_zero_exc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A divide wins over a simultaneous multiply. The multiply
                // is dropped, not queued.
                if (bus.start_div) begin
                    state_d = S_INIT;
                    op_d    = 1'b1;
                end else if (bus.start_mult) begin
                    state_d = S_INIT;
                    op_d    = 1'b0;
                end
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The divider reports a zero denominator only in the first
                // RUN cycle. div_ok means nothing in any other cycle.
                if (op_q && (cnt_q == '0) && !bus.div_ok) begin
                    state_d = S_ZERO;
                end else if (cnt_q == last_cnt) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ZERO:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state. The result is registered above.
    always_comb begin
        mult_init_d    = (state_d == S_INIT) && !op_d;
        div_init_d     = (state_d == S_INIT) && op_d;
        busy_d         = (state_d != S_IDLE);
        hilo_we_d      = (state_d == S_COMMIT);
        done_d         = (state_d == S_COMMIT) || (state_d == S_ZERO);
        div_zero_exc_d = (state_d == S_ZERO);
        // op changes only when a request is accepted, so the select holds
        // through IDLE.
        hilo_sel_d     = op_d;
    end

    assign bus.mult_init    = mult_init_q;
    assign bus.div_init     = div_init_q;
    assign bus.busy         = busy_q;
    assign bus.hilo_we      = hilo_we_q;
    assign bus.hilo_sel     = hilo_sel_q;
    assign bus.done         = done_q;
    assign bus.div_zero_exc = div_zero_exc_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam int DIV_N  = 32;
  localparam int MULT_N = 20;
  localparam int W      = 35;  // {cycle[31:0], hilo_we, div_zero_exc, hilo_sel}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] dbg_state;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.DIV_CYCLES(DIV_N), .MULT_CYCLES(MULT_N), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every completion (done / hilo_we / exception) must match the
  // next expected record, including the cycle it occurs in
  always @(negedge clk) begin
    if (!reset && (bus.done || bus.hilo_we || bus.div_zero_exc)) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {cyc, bus.hilo_we, bus.div_zero_exc, bus.hilo_sel};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion: got cyc=%0d we=%0b exc=%0b sel=%0b done=%0b, required none",
                 cyc, bus.hilo_we, bus.div_zero_exc, bus.hilo_sel, bus.done);
      end else begin
        exp = exp_q.pop_front();
        if (!bus.done || got !== exp) begin
          errors++;
          $display("FAIL completion: got cyc=%0d we/exc/sel=%03b done=%0b, required cyc=%0d we/exc/sel=%03b done=1",
                   cyc, got[2:0], bus.done, exp[34:3], exp[2:0]);
        end
      end
    end
  end

  // driver: caller is 1ns after a rising edge; the request is sampled on the
  // next edge E. Returns in cycle E+1 with e = cycle counter value there.
  task automatic pulse_start(input bit m, input bit d, output int e);
    bus.start_mult = m;
    bus.start_div  = d;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    e = cyc;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus.mult_init, bus.div_init, bus.busy, bus.hilo_we, bus.hilo_sel,
           bus.done, bus.div_zero_exc, dbg_state} !== 10'b0) begin
        errors++;
        $display("FAIL reset_idle: got outs=%07b state=%0d, required all 0",
                 {bus.mult_init, bus.div_init, bus.busy, bus.hilo_we, bus.hilo_sel,
                  bus.done, bus.div_zero_exc}, dbg_state);
      end
    end
  endtask

  task automatic test_div_normal();
    int e, busy_n, dinit_n, minit_n, first_idle, we_k;
    bit sel_init;
    busy_n = 0; dinit_n = 0; minit_n = 0; first_idle = 0; we_k = 0; sel_init = 0;
    pulse_start(0, 1, e);
    exp_q.push_back({32'(e + DIV_N + 1), 3'b101});
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busy_n++; else if (first_idle == 0) first_idle = k;
      if (bus.div_init) begin dinit_n++; if (k != 1) dinit_n += 100; end
      if (bus.mult_init) minit_n++;
      if (bus.hilo_we) we_k = k;
      if (k == 1) sel_init = bus.hilo_sel;
      step();
    end
    checks++; if (dinit_n !== 1) begin errors++; $display("FAIL div_init_pulse: got %0d, required 1 at E+1", dinit_n); end
    checks++; if (minit_n !== 0) begin errors++; $display("FAIL div_no_mult_init: got %0d, required 0", minit_n); end
    checks++; if (busy_n !== DIV_N + 2) begin errors++; $display("FAIL div_busy_len: got %0d, required %0d", busy_n, DIV_N + 2); end
    checks++; if (first_idle !== DIV_N + 3) begin errors++; $display("FAIL div_idle_at: got E+%0d, required E+%0d", first_idle, DIV_N + 3); end
    checks++; if (we_k !== DIV_N + 2) begin errors++; $display("FAIL div_we_at: got E+%0d, required E+%0d", we_k, DIV_N + 2); end
    checks++; if (sel_init !== 1'b1) begin errors++; $display("FAIL div_sel_init: got %0b, required 1", sel_init); end
  endtask

  task automatic test_div_zero();
    int e, busy_n, first_idle, exc_k, we_n;
    busy_n = 0; first_idle = 0; exc_k = 0; we_n = 0;
    pulse_start(0, 1, e);
    exp_q.push_back({32'(e + 2), 3'b011});
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) bus.div_ok = 1'b0;
      if (k == 3) bus.div_ok = 1'b1;
      if (bus.busy) busy_n++; else if (first_idle == 0) first_idle = k;
      if (bus.div_zero_exc) exc_k = k;
      if (bus.hilo_we) we_n++;
      step();
    end
    checks++; if (exc_k !== 3) begin errors++; $display("FAIL zero_exc_at: got E+%0d, required E+3", exc_k); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL zero_no_we: got %0d, required 0", we_n); end
    checks++; if (busy_n !== 3) begin errors++; $display("FAIL zero_busy_len: got %0d, required 3", busy_n); end
    checks++; if (first_idle !== 4) begin errors++; $display("FAIL zero_idle_at: got E+%0d, required E+4", first_idle); end
  endtask

  task automatic test_both_start();
    int e, dinit_n, minit_n;
    bit sel_init, sel_commit;
    dinit_n = 0; minit_n = 0; sel_init = 0; sel_commit = 0;
    pulse_start(1, 1, e);
    exp_q.push_back({32'(e + DIV_N + 1), 3'b101});
    for (int k = 1; k <= 38; k++) begin
      if (k == 10) bus.start_mult = 1'b1;
      if (k == 11) bus.start_mult = 1'b0;
      if (bus.div_init) dinit_n++;
      if (bus.mult_init) minit_n++;
      if (k == 1) sel_init = bus.hilo_sel;
      if (k == DIV_N + 2) sel_commit = bus.hilo_sel;
      step();
    end
    checks++; if (dinit_n !== 1) begin errors++; $display("FAIL both_div_init: got %0d, required 1", dinit_n); end
    checks++; if (minit_n !== 0) begin errors++; $display("FAIL both_no_mult_init: got %0d, required 0", minit_n); end
    checks++; if ({sel_init, sel_commit} !== 2'b11) begin errors++; $display("FAIL both_sel: got %02b, required 11", {sel_init, sel_commit}); end
  endtask

  task automatic test_reset_mid_run();
    int e, minit_n, we_k, busy_n;
    minit_n = 0; we_k = 0; busy_n = 0;
    pulse_start(0, 1, e);
    for (int k = 1; k <= 11; k++) step();
    // cycle E+12: RUN count 10
    checks++;
    if (dbg_state !== 3'd2) begin errors++; $display("FAIL mid_run_state: got %0d, required 2", dbg_state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.hilo_we, bus.hilo_sel, dbg_state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%0b done=%0b we=%0b sel=%0b state=%0d, required all 0",
               bus.busy, bus.done, bus.hilo_we, bus.hilo_sel, dbg_state);
    end
    repeat (2) step();
    pulse_start(1, 0, e);
    exp_q.push_back({32'(e + MULT_N + 1), 3'b100});
    for (int k = 1; k <= MULT_N + 5; k++) begin
      if (bus.mult_init && k == 1) minit_n++;
      if (bus.busy) busy_n++;
      if (bus.hilo_we) we_k = k;
      step();
    end
    checks++; if (minit_n !== 1) begin errors++; $display("FAIL mult_init_pulse: got %0d, required 1", minit_n); end
    checks++; if (we_k !== MULT_N + 2) begin errors++; $display("FAIL mult_we_at: got E+%0d, required E+%0d", we_k, MULT_N + 2); end
    checks++; if (busy_n !== MULT_N + 2) begin errors++; $display("FAIL mult_busy_len: got %0d, required %0d", busy_n, MULT_N + 2); end
  endtask

  task automatic test_back_to_back();
    int e, dinit_n;
    dinit_n = 0;
    pulse_start(1, 0, e);
    exp_q.push_back({32'(e + MULT_N + 1), 3'b100});
    exp_q.push_back({32'(e + MULT_N + 3 + MULT_N + 1), 3'b100});
    for (int k = 1; k <= 2 * MULT_N + 8; k++) begin
      if (k == MULT_N + 2) bus.start_div = 1'b1;   // during COMMIT: ignored
      if (k == MULT_N + 3) begin                   // first IDLE cycle
        bus.start_div = 1'b0;
        bus.start_mult = 1'b1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%0b, required 0", bus.busy); end
      end
      if (k == MULT_N + 4) begin
        bus.start_mult = 1'b0;
        checks++;
        if ({bus.mult_init, bus.busy, bus.hilo_sel} !== 3'b110) begin
          errors++;
          $display("FAIL b2b_mult_init: got init/busy/sel=%03b, required 110",
                   {bus.mult_init, bus.busy, bus.hilo_sel});
        end
      end
      if (bus.div_init) dinit_n++;
      step();
    end
    checks++; if (dinit_n !== 0) begin errors++; $display("FAIL b2b_commit_start_ignored: got %0d div_init, required 0", dinit_n); end
  endtask

  initial begin
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.div_ok     = 1'b1;
    #1;
    test_reset();
    test_div_normal();
    repeat ($urandom_range(1, 3)) step();
    test_div_zero();
    repeat ($urandom_range(1, 3)) step();
    test_both_start();
    test_reset_mid_run();
    test_back_to_back();
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_completions: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
